ifetch_mem_resp: RTL and testbench
==================================

Name: ifetch_mem_resp

Overview:
- Instruction-memory responder: the memory-side end of the fetch request/response interface driven by the fetch unit.
- Accepts a fetch request with a byte address, reads a word-addressed instruction store, and returns the word with a valid flag after a programmed latency.
- Holds the response until the fetch side accepts it.
- Also provides a word-write port for program loading by the sim/test harness.

Parameters:
- ADDR_W, 32, request/load address width
- DATA_W, 32, instruction word width
- DEPTH_LOG2, 12, log2 of store depth in words (4096 words)
- BASE_ADDR, 32'h80000000, byte address of word 0; matches the fetch reset PC
- LATENCY, 2, cycles from request accept edge to rvalid rising; legal range 1..15

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous assert, active-low
- req  in  1  fetch request valid
- addr  in  ADDR_W  fetch byte address, sampled on accept
- req_ready  out  1  request can be accepted this cycle
- rvalid  out  1  response valid
- rdata  out  DATA_W  instruction word
- rerr  out  1  access fault flag, qualified by rvalid
- rready  in  1  fetch side accepts the response
- wen  in  1  load-port word write enable
- waddr  in  ADDR_W  load-port byte address
- wdata  in  DATA_W  load-port write data

Behaviour:
- Reset: rst_n low asynchronously forces state IDLE, rvalid=0, rdata=0, rerr=0, latency counter=0. req_ready=1 after release. Store contents are not reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - req=1 at a rising edge accepts the request: latch addr, load counter.
  - Next state is WAIT, or RESP directly when LATENCY=1.
- WAIT:
  - req_ready=0; req ignored.
  - Counter decrements each cycle.
  - Transition to RESP such that rvalid rises exactly LATENCY cycles after the accept edge.
- RESP:
  - rvalid=1; req_ready=0.
  - rdata and rerr are registered on the RESP-entry edge and held stable until handshake.
  - rvalid & rready at an edge completes the handshake: return to IDLE, rvalid=0.
  - rdata retains its last value.
- Throughput: one request per LATENCY+1 cycles minimum. A request held high through RESP is accepted in the following IDLE cycle.
- Address decode:
  - Index = (addr - BASE_ADDR) >> 2, modular ADDR_W subtraction.
  - Fault when addr[1:0] != 0, or (addr - BASE_ADDR) >= 4 << DEPTH_LOG2; this includes addresses below BASE_ADDR, which wrap to large values.
  - Faulted response: rerr=1, rdata=0, same latency and handshake as a normal response.
- Load port:
  - wen=1 writes wdata to the word at waddr on the rising edge.
  - Misaligned or out-of-range waddr is silently dropped.
  - Writes are legal in any state.
- Read/write collision: a write to the pending index on the RESP-entry edge is not visible in that response (read-before-write). Earlier writes are visible.
- rready while rvalid=0 is ignored.
- Reset asserted in WAIT or RESP aborts the transaction. No response is produced after release.

Optional Feature:
- Macro: IFETCH_MEM_RESP_RAND_DELAY_EN.
- Defined:
  - A 4-bit Fibonacci LFSR (taps 4,3; reset seed 4'b1001) advances on every accept.
  - Its low 2 bits add 0..3 extra WAIT cycles to that request.
  - The LATENCY=1 direct path is replaced by WAIT when the extra delay is nonzero.
  - This stresses fetch-side stall handling.
- Undefined: latency is exactly LATENCY, no LFSR logic.

Test Plan:
- Load word 0 = 32'h00000413 via load port; req=1, addr=32'h80000000, rready=1 -> rvalid high exactly 2 cycles after accept, rdata=32'h00000413, rerr=0, one-cycle pulse.
- Back-to-back: req held high, rready=1, words 0..3 loaded 1,2,3,4, addr stepping +4 per handshake -> rdata sequence 1,2,3,4; each rvalid 3 cycles apart; no duplicate or skipped words.
- Backpressure: rready=0 for 5 cycles after rvalid -> rvalid and rdata stable all 5 cycles; req_ready=0; handshake on the cycle rready rises.
- Faults: addr=32'h80000002, then 32'h80004000, then 32'h7FFFFFFC -> each response rerr=1, rdata=0, normal latency.
- Collision: write word 5 = 32'hDEADBEEF on the RESP-entry edge of a read of 32'h80000014 (old value 32'h12345678) -> response 32'h12345678; next read of the same address returns 32'hDEADBEEF.
- Reset mid-WAIT: assert rst_n low one cycle after accept, release -> rvalid stays 0, state IDLE, req_ready=1; store contents preserved.

Source files
------------

// File: rtl/ifetch_mem_resp.sv
// Instruction-memory responder: accepts a fetch request, reads the word store and
// returns the word after LATENCY cycles, holding it until rready.
// Optional macro IFETCH_MEM_RESP_RAND_DELAY_EN adds 0..3 LFSR-driven extra wait cycles.
module ifetch_mem_resp #(
  parameter int                 ADDR_W     = 32,
  parameter int                 DATA_W     = 32,
  parameter int                 DEPTH_LOG2 = 12,
  parameter logic [ADDR_W-1:0]  BASE_ADDR  = 32'h80000000,
  parameter int                 LATENCY    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic [ADDR_W-1:0] addr,
  output logic              req_ready,
  output logic              rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              rerr,
  input  logic              rready,
  input  logic              wen,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata
);

  localparam int              DEPTH = 1 << DEPTH_LOG2;
  localparam logic [ADDR_W:0] SPAN  = (ADDR_W+1)'(4) << DEPTH_LOG2;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t              state_q, state_d;
  logic [4:0]          cnt_q;
  logic [4:0]          lat_load;
  logic [4:0]          extra;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                rerr_q;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic                accept, resp_enter;
  logic [ADDR_W-1:0]   rd_addr, rd_off, wr_off;
  logic                rd_fault, wr_fault;
  logic [DEPTH_LOG2-1:0] rd_idx, wr_idx;

  assign accept   = (state_q == IDLE) && req;
  // Direct IDLE->RESP entry reads with the live address; otherwise the latched one.
  assign rd_addr  = (state_q == IDLE) ? addr : addr_q;
  assign rd_off   = rd_addr - BASE_ADDR;
  assign rd_fault = (rd_addr[1:0] != 2'b00) || ({1'b0, rd_off} >= SPAN);
  assign rd_idx   = rd_off[DEPTH_LOG2+1:2];
  assign wr_off   = waddr - BASE_ADDR;
  assign wr_fault = (waddr[1:0] != 2'b00) || ({1'b0, wr_off} >= SPAN);
  assign wr_idx   = wr_off[DEPTH_LOG2+1:2];

`ifdef IFETCH_MEM_RESP_RAND_DELAY_EN
  logic [3:0] lfsr_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      lfsr_q <= 4'b1001;
    else if (accept) lfsr_q <= {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};
  end
  assign extra = {3'b000, lfsr_q[1:0]};
`else
  assign extra = 5'd0;
`endif

  // Number of WAIT cycles after accept; zero means straight to RESP.
  assign lat_load = 5'(LATENCY - 1) + extra;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (req) state_d = (lat_load == 5'd0) ? RESP : WAIT;
      WAIT: if (cnt_q <= 5'd1) state_d = RESP;
      RESP: if (rready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    rvalid    = 1'b0;
    case (state_q)
      IDLE:    req_ready = 1'b1;
      RESP:    rvalid    = 1'b1;
      default: ;
    endcase
  end

  assign resp_enter = (state_d == RESP) && (state_q != RESP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= 5'd0;
      addr_q  <= '0;
      rdata_q <= '0;
      rerr_q  <= 1'b0;
    end else begin
      if (accept) begin
        cnt_q  <= lat_load;
        addr_q <= addr;
      end else if (state_q == WAIT) begin
        cnt_q  <= cnt_q - 5'd1;
      end
      // Read happens on the entry edge, so a same-edge write is not seen.
      if (resp_enter) begin
        rdata_q <= rd_fault ? '0 : mem[rd_idx];
        rerr_q  <= rd_fault;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wen && !wr_fault) mem[wr_idx] <= wdata;
  end

  assign rdata = rdata_q;
  assign rerr  = rerr_q;

endmodule

// File: tb/tb_ifetch_mem_resp.sv
// Self-checking bench for ifetch_mem_resp: directed scenarios plus randomized
// transactions compared against an associative-array model of the store.
module tb_ifetch_mem_resp;
  localparam int          LAT  = 2;
  localparam logic [31:0] BASE = 32'h80000000;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        req = 1'b0, rready = 1'b0, wen = 1'b0;
  logic [31:0] addr = '0, waddr = '0, wdata = '0;
  logic        req_ready, rvalid, rerr;
  logic [31:0] rdata;

  int n_checks = 0, n_fail = 0, cyc = 0;
  logic [31:0] model [int];

  ifetch_mem_resp #(.ADDR_W(32), .DATA_W(32), .DEPTH_LOG2(12), .BASE_ADDR(BASE), .LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .addr(addr), .req_ready(req_ready),
    .rvalid(rvalid), .rdata(rdata), .rerr(rerr), .rready(rready),
    .wen(wen), .waddr(waddr), .wdata(wdata));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic step();
    @(posedge clk); #1;
  endtask

  function automatic bit exp_err(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return (a[1:0] != 2'b00) || (off >= 32'h4000);
  endfunction

  function automatic logic [31:0] exp_data(input logic [31:0] a);
    if (exp_err(a)) return 32'h0;
    return model[int'((a - BASE) >> 2)];
  endfunction

  task automatic load(input logic [31:0] a, input logic [31:0] d);
    wen = 1'b1; waddr = a; wdata = d;
    step();
    wen = 1'b0;
    if (!exp_err(a)) model[int'((a - BASE) >> 2)] = d;
  endtask

  // Runs one request; returns observed latency, data, flag and handshake behaviour.
  task automatic txn(input logic [31:0] a, input int hold, output int lat,
                     output logic [31:0] d, output logic e, output bit stable, output bit done);
    req = 1'b1; addr = a; rready = (hold == 0);
    step();
    req = 1'b0; lat = 1;
    while (rvalid !== 1'b1 && lat < 40) begin step(); lat++; end
    d = rdata; e = rerr; stable = 1'b1;
    for (int h = 0; h < hold; h++) begin
      step();
      if (rvalid !== 1'b1 || rdata !== d || rerr !== e || req_ready !== 1'b0) stable = 1'b0;
    end
    rready = 1'b1;
    step();
    done = (rvalid === 1'b0);
    rready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    n_checks++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid got %b exp 0", rvalid); end
    n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got %h exp 0", rdata); end
    n_checks++; if (rerr !== 1'b0) begin n_fail++; $display("FAIL reset_rerr got %b exp 0", rerr); end
    step(); step();
    rst_n = 1'b1;
    step();
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready got %b exp 1", req_ready); end
  endtask

  task automatic test_basic();
    int lat; logic [31:0] d; logic e; bit st, dn;
    load(BASE, 32'h00000413);
    txn(BASE, 0, lat, d, e, st, dn);
    n_checks++; if (lat != LAT) begin n_fail++; $display("FAIL basic_latency got %0d exp %0d", lat, LAT); end
    n_checks++; if (d !== 32'h00000413) begin n_fail++; $display("FAIL basic_rdata got %h exp 00000413", d); end
    n_checks++; if (e !== 1'b0) begin n_fail++; $display("FAIL basic_rerr got %b exp 0", e); end
    n_checks++; if (!dn) begin n_fail++; $display("FAIL basic_pulse rvalid still high after handshake"); end
  endtask

  task automatic test_back_to_back();
    int k, last;
    for (int i = 0; i < 4; i++) load(BASE + 32'(4*i), 32'(i + 1));
    req = 1'b1; addr = BASE; rready = 1'b1; k = 0; last = 0;
    for (int c = 0; c < 40 && k < 4; c++) begin
      step();
      if (rvalid === 1'b1) begin
        n_checks++; if (rdata !== 32'(k + 1)) begin n_fail++; $display("FAIL b2b_data[%0d] got %h exp %h", k, rdata, k + 1); end
        if (k > 0) begin
          n_checks++; if (cyc - last != LAT + 1) begin n_fail++; $display("FAIL b2b_gap[%0d] got %0d exp %0d", k, cyc - last, LAT + 1); end
        end
        last = cyc; k++; addr = BASE + 32'(4*k);
      end
    end
    req = 1'b0;
    n_checks++; if (k != 4) begin n_fail++; $display("FAIL b2b_count got %0d exp 4", k); end
    step(); step();
    rready = 1'b0;
  endtask

  task automatic test_backpressure();
    int lat; logic [31:0] d; logic e; bit st, dn;
    load(BASE + 32'h18, 32'hCAFEF00D);
    txn(BASE + 32'h18, 5, lat, d, e, st, dn);
    n_checks++; if (lat != LAT) begin n_fail++; $display("FAIL bp_latency got %0d exp %0d", lat, LAT); end
    n_checks++; if (d !== 32'hCAFEF00D) begin n_fail++; $display("FAIL bp_rdata got %h exp cafef00d", d); end
    n_checks++; if (!st) begin n_fail++; $display("FAIL bp_stable response changed or req_ready high while held"); end
    n_checks++; if (!dn) begin n_fail++; $display("FAIL bp_handshake rvalid still high after rready"); end
  endtask

  task automatic test_faults();
    logic [31:0] fa [3];
    int lat; logic [31:0] d; logic e; bit st, dn;
    fa[0] = 32'h80000002; fa[1] = 32'h80004000; fa[2] = 32'h7FFFFFFC;
    for (int i = 0; i < 3; i++) begin
      txn(fa[i], 0, lat, d, e, st, dn);
      n_checks++; if (e !== 1'b1) begin n_fail++; $display("FAIL fault_rerr[%h] got %b exp 1", fa[i], e); end
      n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL fault_rdata[%h] got %h exp 0", fa[i], d); end
      n_checks++; if (lat != LAT) begin n_fail++; $display("FAIL fault_latency[%h] got %0d exp %0d", fa[i], lat, LAT); end
    end
  endtask

  task automatic test_collision();
    int lat; logic [31:0] d; logic e; bit st, dn;
    load(BASE + 32'h14, 32'h12345678);
    req = 1'b1; addr = BASE + 32'h14; rready = 1'b0;
    step();
    req = 1'b0;
    repeat (LAT - 2) step();
    wen = 1'b1; waddr = BASE + 32'h14; wdata = 32'hDEADBEEF;
    step();
    wen = 1'b0;
    n_checks++; if (rvalid !== 1'b1) begin n_fail++; $display("FAIL coll_rvalid got %b exp 1", rvalid); end
    n_checks++; if (rdata !== 32'h12345678) begin n_fail++; $display("FAIL coll_old got %h exp 12345678", rdata); end
    model[5] = 32'hDEADBEEF;
    rready = 1'b1; step(); rready = 1'b0;
    txn(BASE + 32'h14, 0, lat, d, e, st, dn);
    n_checks++; if (d !== 32'hDEADBEEF) begin n_fail++; $display("FAIL coll_new got %h exp deadbeef", d); end
  endtask

  task automatic test_reset_mid_wait();
    int lat; logic [31:0] d; logic e; bit st, dn, quiet;
    req = 1'b1; addr = BASE;
    step();
    req = 1'b0; rst_n = 1'b0;
    step();
    rst_n = 1'b1; quiet = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      if (rvalid !== 1'b0 || req_ready !== 1'b1) quiet = 1'b0;
    end
    n_checks++; if (!quiet) begin n_fail++; $display("FAIL rst_abort rvalid=%b req_ready=%b exp 0/1", rvalid, req_ready); end
    txn(BASE, 0, lat, d, e, st, dn);
    n_checks++; if (d !== exp_data(BASE)) begin n_fail++; $display("FAIL rst_preserve got %h exp %h", d, exp_data(BASE)); end
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    case (r)
      6:       return BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(1, 3));
      7:       return BASE + 32'h4000 + 32'(4 * $urandom_range(0, 1000));
      8:       return BASE - 32'(4 * $urandom_range(1, 1000));
      default: return BASE + 32'(4 * $urandom_range(0, 15));
    endcase
  endfunction

  task automatic test_random();
    int lat; logic [31:0] d, a, ed; logic e; bit st, dn;
    for (int i = 0; i < 16; i++) load(BASE + 32'(4*i), $urandom);
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 2) == 0) load(rand_addr(), $urandom);
      a = rand_addr();
      ed = exp_data(a);
      txn(a, $urandom_range(0, 3), lat, d, e, st, dn);
      n_checks++; if (lat != LAT) begin n_fail++; $display("FAIL rnd_latency[%0d] addr %h got %0d exp %0d", n, a, lat, LAT); end
      n_checks++; if (d !== ed) begin n_fail++; $display("FAIL rnd_rdata[%0d] addr %h got %h exp %h", n, a, d, ed); end
      n_checks++; if (e !== exp_err(a)) begin n_fail++; $display("FAIL rnd_rerr[%0d] addr %h got %b exp %b", n, a, e, exp_err(a)); end
      n_checks++; if (!(st && dn)) begin n_fail++; $display("FAIL rnd_handshake[%0d] stable %b done %b exp 1/1", n, st, dn); end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_faults();
    test_collision();
    test_reset_mid_wait();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
